slurm32_icache: RTL and testbench

Direct-mapped, read-only instruction cache. It sits between the SLURM32 pipeline fetch port and the memory bus. It answers the pipeline's instruction_request/instruction_address with a registered instruction_in/instruction_valid pair one cycle later. On a miss it drops valid, which sends the pipeline into its instruction-stall/rewind sequence, then fills the full line from memory with a word-by-word handshake.

---
 rtl/slurm32_icache.sv | 172 +++++++++++++++++
 tb/tb_slurm32_icache.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slurm32_icache.sv
// Direct-mapped, read-only instruction cache between the SLURM32 fetch port and the memory bus.
// Optional hit/miss counters are enabled by defining SLURM32_ICACHE_STATS_EN.
module slurm32_icache #(
  parameter int BITS         = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int INDEX_BITS   = 8,
  parameter int OFFSET_BITS  = 2
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic                    instruction_request,
  input  logic [ADDRESS_BITS-1:0] instruction_address,
  output logic                    instruction_valid,
  output logic [BITS-1:0]         instruction_in,
  input  logic                    invalidate,
  output logic                    mem_request,
  output logic [ADDRESS_BITS-1:0] mem_address,
  input  logic                    mem_valid,
  input  logic [BITS-1:0]         mem_data,
`ifdef SLURM32_ICACHE_STATS_EN
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count,
`endif
  output logic                    busy
);

  localparam int TAG_BITS = ADDRESS_BITS - INDEX_BITS - OFFSET_BITS - 2;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << (INDEX_BITS + OFFSET_BITS);

  typedef enum logic [1:0] {
    st_flush,
    st_lookup,
    st_fill,
    st_fill_done
  } state_t;

  state_t state, state_nxt;

  logic [INDEX_BITS-1:0]  flush_cnt;
  logic [OFFSET_BITS-1:0] word_cnt;

  // Address fields of the request presented this cycle.
  logic [OFFSET_BITS-1:0] addr_offset;
  logic [INDEX_BITS-1:0]  addr_index;
  logic [TAG_BITS-1:0]    addr_tag;
  logic                   unused_addr_bits;

  assign addr_offset      = instruction_address[OFFSET_BITS+1:2];
  assign addr_index       = instruction_address[INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2];
  assign addr_tag         = instruction_address[ADDRESS_BITS-1:INDEX_BITS+OFFSET_BITS+2];
  assign unused_addr_bits = ^instruction_address[1:0];

  // Sampled request; also serves as the miss address for the whole fill.
  logic                  req_q;
  logic [TAG_BITS-1:0]   lookup_tag;
  logic [INDEX_BITS-1:0] lookup_index;

  // Storage
  logic [TAG_BITS-1:0] tag_ram  [LINES];
  logic [BITS-1:0]     data_ram [WORDS];
  logic [LINES-1:0]    valid_bits;
  logic [TAG_BITS-1:0] tag_q;
  logic [BITS-1:0]     data_q;
  logic                valid_q;
  logic [BITS-1:0]     instr_last;

  logic tag_match;
  logic lookup_hit;
  logic lookup_miss;
  logic sample;
  logic fill_accept;

  assign tag_match   = valid_q && (tag_q == lookup_tag);
  assign lookup_hit  = (state == st_lookup) && req_q && tag_match;
  assign lookup_miss = (state == st_lookup) && req_q && !tag_match;

  // A miss cycle must not sample: the FSM leaves st_lookup on the next edge.
  assign sample      = (state == st_lookup) && instruction_request && !invalidate && !lookup_miss;
  assign fill_accept = (state == st_fill) && mem_valid && !invalidate;

  assign instruction_valid = lookup_hit;
  assign instruction_in    = lookup_hit ? data_q : instr_last;
  assign mem_request       = (state == st_fill);
  assign mem_address       = mem_request ? {lookup_tag, lookup_index, word_cnt, 2'b00} : '0;
  assign busy              = (state == st_flush) || (state == st_fill);

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      st_flush: begin
        if (!invalidate && (flush_cnt == '1)) state_nxt = st_lookup;
      end
      st_lookup: begin
        if (invalidate)       state_nxt = st_flush;
        else if (lookup_miss) state_nxt = st_fill;
      end
      st_fill: begin
        if (invalidate)                            state_nxt = st_flush;
        else if (fill_accept && (word_cnt == '1)) state_nxt = st_fill_done;
      end
      st_fill_done: begin
        state_nxt = invalidate ? st_flush : st_lookup;
      end
      default: state_nxt = st_flush;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state      <= st_flush;
      flush_cnt  <= '0;
      word_cnt   <= '0;
      req_q      <= 1'b0;
      instr_last <= '0;
    end else begin
      state <= state_nxt;
      req_q <= sample;

      if (invalidate)             flush_cnt <= '0;
      else if (state == st_flush) flush_cnt <= flush_cnt + 1'b1;

      if (lookup_miss)      word_cnt <= '0;
      else if (fill_accept) word_cnt <= word_cnt + 1'b1;

      if (lookup_hit) instr_last <= data_q;
    end
  end

  // NOTE: storage arrays and their read registers are not reset; the flush walk clears the valid bits instead.
  always_ff @(posedge CLK) begin
    if (sample) begin
      lookup_tag   <= addr_tag;
      lookup_index <= addr_index;
    end
  end

  always_ff @(posedge CLK) begin
    if (state == st_flush)
      valid_bits[flush_cnt] <= 1'b0;
    else if ((state == st_fill_done) && !invalidate)
      valid_bits[lookup_index] <= 1'b1;
    if (sample) valid_q <= valid_bits[addr_index];
  end

  always_ff @(posedge CLK) begin
    if ((state == st_fill_done) && !invalidate) tag_ram[lookup_index] <= lookup_tag;
    if (sample) tag_q <= tag_ram[addr_index];
  end

  always_ff @(posedge CLK) begin
    if (fill_accept) data_ram[{lookup_index, word_cnt}] <= mem_data;
    if (sample) data_q <= data_ram[{addr_index, addr_offset}];
  end

`ifdef SLURM32_ICACHE_STATS_EN
  // Saturating counters, cleared together with the cache contents.
  always_ff @(posedge CLK) begin
    if (!RSTb || invalidate) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (lookup_hit && (hit_count != '1)) hit_count <= hit_count + 1'b1;
      if ((state == st_lookup) && (state_nxt == st_fill) && (miss_count != '1))
        miss_count <= miss_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_slurm32_icache.sv
// Self-checking bench for slurm32_icache: directed fetch sequences against a memory model
// with programmable response delay; stats checks when SLURM32_ICACHE_STATS_EN is defined.
module tb_slurm32_icache;

  logic        CLK = 1'b0;
  logic        RSTb = 1'b0;
  logic        instruction_request = 1'b0;
  logic [31:0] instruction_address = '0;
  logic        instruction_valid;
  logic [31:0] instruction_in;
  logic        invalidate = 1'b0;
  logic        mem_request;
  logic [31:0] mem_address;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data = '0;
  logic        busy;
`ifdef SLURM32_ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  slurm32_icache dut (
    .CLK                (CLK),
    .RSTb               (RSTb),
    .instruction_request(instruction_request),
    .instruction_address(instruction_address),
    .instruction_valid  (instruction_valid),
    .instruction_in     (instruction_in),
    .invalidate         (invalidate),
    .mem_request        (mem_request),
    .mem_address        (mem_address),
    .mem_valid          (mem_valid),
    .mem_data           (mem_data),
`ifdef SLURM32_ICACHE_STATS_EN
    .hit_count          (hit_count),
    .miss_count         (miss_count),
`endif
    .busy               (busy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory responder: answers after mem_delay wait cycles, and drives junk
  // mem_valid pulses while no request is outstanding.
  int          mem_delay  = 0;
  bit          noise_en   = 1'b1;
  int          wait_cnt   = 0;
  int          stable_err = 0;
  logic [31:0] prev_addr  = '0;

  initial begin
    forever begin
      @(negedge CLK);
      if (mem_request === 1'b1) begin
        if (wait_cnt > 0 && mem_address !== prev_addr) stable_err++;
        prev_addr = mem_address;
        if (wait_cnt >= mem_delay) begin
          mem_valid = 1'b1;
          mem_data  = mem_model(mem_address);
          wait_cnt  = 0;
        end else begin
          mem_valid = 1'b0;
          mem_data  = 32'hDEAD_BEEF;
          wait_cnt++;
        end
      end else begin
        wait_cnt  = 0;
        mem_valid = noise_en;
        mem_data  = 32'hBAD0_0BAD;
      end
    end
  end

  // Log of every word the cache accepted from memory.
  logic [31:0] acc_log[$];
  always @(posedge CLK) begin
    if (mem_request === 1'b1 && mem_valid === 1'b1) acc_log.push_back(mem_address);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All tasks start and end just after a falling edge.
  task automatic fetch(input logic [31:0] a, output logic v, output logic [31:0] d);
    instruction_request = 1'b1;
    instruction_address = a;
    @(negedge CLK);
    v = instruction_valid;
    d = instruction_in;
    instruction_request = 1'b0;
  endtask

  task automatic wait_idle(input string name, output int req_cycles);
    int n = 0;
    req_cycles = 0;
    while (busy !== 1'b0 && n < 2000) begin
      if (mem_request === 1'b1) req_cycles++;
      @(negedge CLK);
      n++;
    end
    check({name, "_idle_timeout"}, 32'(n < 2000), 32'd1);
    @(negedge CLK);
  endtask

  task automatic count_flush(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge CLK);
    end
    check(name, n, 256);
  endtask

  // Miss on a, check the fill walks the line from word 0, then hit on a.
  task automatic miss_fill(input logic [31:0] a, input string name, input int exp_req_cycles);
    logic        v;
    logic [31:0] d;
    logic [31:0] got;
    logic [31:0] base;
    int          start;
    int          cyc;
    base = {a[31:4], 4'h0};
    fetch(a, v, d);
    check({name, "_miss"}, v, 0);
    start = acc_log.size();
    @(negedge CLK);
    wait_idle(name, cyc);
    check({name, "_fill_cycles"}, cyc, exp_req_cycles);
    check({name, "_fill_words"}, acc_log.size() - start, 4);
    for (int k = 0; k < 4; k++) begin
      got = (start + k < acc_log.size()) ? acc_log[start + k] : 32'hFFFF_FFFF;
      check({name, "_mem_addr"}, got, base + 32'(4 * k));
    end
    fetch(a, v, d);
    check({name, "_hit_valid"}, v, 1);
    check({name, "_hit_data"}, d, mem_model(a));
  endtask

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        exp_v;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic        v;
    logic [31:0] d;
    int          start;
    int          n;

    vecs[0] = '{1'b1, 32'h100, 1'b1, 32'hC0DE_0100};
    vecs[1] = '{1'b1, 32'h104, 1'b1, 32'hC0DE_0104};
    vecs[2] = '{1'b1, 32'h108, 1'b1, 32'hC0DE_0108};
    vecs[3] = '{1'b1, 32'h10C, 1'b1, 32'hC0DE_010C};
    vecs[4] = '{1'b0, 32'h000, 1'b0, 32'hC0DE_010C};
    vecs[5] = '{1'b1, 32'h104, 1'b1, 32'hC0DE_0104};
    vecs[6] = '{1'b0, 32'h000, 1'b0, 32'hC0DE_0104};

    // Reset values
    repeat (3) @(negedge CLK);
    check("rst_valid", instruction_valid, 0);
    check("rst_instr", instruction_in, 32'h0);
    check("rst_mem_req", mem_request, 0);
    check("rst_mem_addr", mem_address, 32'h0);
    check("rst_busy", busy, 1);
`ifdef SLURM32_ICACHE_STATS_EN
    check("rst_hits", hit_count, 0);
    check("rst_misses", miss_count, 0);
`endif
    RSTb = 1'b1;
    count_flush("rst_flush_cycles");

    // First miss and fill of line 0x100
    mem_delay = 0;
    miss_fill(32'h100, "fill100", 4);

    // Back-to-back hits and idle cycles from the vector table
    for (int i = 0; i < 7; i++) begin
      instruction_request = vecs[i].req;
      instruction_address = vecs[i].addr;
      @(negedge CLK);
      check($sformatf("vec%0d_valid", i), instruction_valid, vecs[i].exp_v);
      check($sformatf("vec%0d_data", i), instruction_in, vecs[i].exp_d);
      check($sformatf("vec%0d_mem_req", i), mem_request, 0);
    end
    instruction_request = 1'b0;

    // Slow memory: 3 wait cycles per word
    mem_delay  = 3;
    stable_err = 0;
    miss_fill(32'h308, "slow300", 16);
    check("slow_addr_stable", stable_err, 0);
    for (int k = 0; k < 4; k++) begin
      fetch(32'h300 + 32'(4 * k), v, d);
      check($sformatf("slow_word%0d", k), d, mem_model(32'h300 + 32'(4 * k)));
    end
    mem_delay = 0;

    // Conflict eviction on index 0x10
    miss_fill(32'h1100, "conflict1100", 4);
    miss_fill(32'h104, "refill100", 4);

    // Invalidate after the second fill word, with a coincident mem_valid
    fetch(32'h500, v, d);
    check("inv_fill_miss", v, 0);
    start = acc_log.size();
    @(negedge CLK);
    n = 0;
    while (acc_log.size() < start + 2 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("inv_wait_words", 32'(n < 100), 32'd1);
    invalidate = 1'b1;
    @(negedge CLK);
    invalidate = 1'b0;
    check("inv_mem_req_drop", mem_request, 0);
    check("inv_busy", busy, 1);
    check("inv_valid", instruction_valid, 0);
    count_flush("inv_flush_cycles");
    miss_fill(32'h100, "post_inv100", 4);
    miss_fill(32'h500, "post_inv500", 4);

    // Reset in the middle of a fill
    fetch(32'h600, v, d);
    start = acc_log.size();
    @(negedge CLK);
    n = 0;
    while (acc_log.size() < start + 2 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    RSTb = 1'b0;
    @(negedge CLK);
    check("rst_fill_mem_req", mem_request, 0);
    check("rst_fill_busy", busy, 1);
    RSTb = 1'b1;
    count_flush("rst_fill_flush_cycles");
    miss_fill(32'h600, "post_rst600", 4);

    // Invalidate while idle in lookup
    invalidate = 1'b1;
    @(negedge CLK);
    invalidate = 1'b0;
    check("inv_lookup_busy", busy, 1);
    check("inv_lookup_valid", instruction_valid, 0);
`ifdef SLURM32_ICACHE_STATS_EN
    check("inv_hits_clear", hit_count, 0);
    check("inv_misses_clear", miss_count, 0);
`endif
    count_flush("inv_lookup_flush_cycles");

`ifdef SLURM32_ICACHE_STATS_EN
    // One miss (plus the hit inside miss_fill) followed by six more hits
    miss_fill(32'h200, "stats200", 4);
    for (int k = 0; k < 6; k++) begin
      fetch(32'h200 + 32'(4 * (k % 4)), v, d);
      check($sformatf("stats_hit%0d", k), v, 1);
    end
    check("stats_hits", hit_count, 7);
    check("stats_misses", miss_count, 1);
    invalidate = 1'b1;
    @(negedge CLK);
    invalidate = 1'b0;
    check("stats_hits_inv", hit_count, 0);
    check("stats_misses_inv", miss_count, 0);
    count_flush("stats_flush_cycles");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
